// File: rtl/tx_wkram_dbuf_pkg.sv
// Shared types and helpers for the double-buffered work RAM.
// edge_pattern gives the synchroniser value that marks one clean strobe rise.
package txwkram_pkg;

  typedef enum logic {ST_IDLE, ST_PEND} txwk_state_t;

  // {1'b0, stages ones}: the oldest sample low, the newest 'stages' samples high
  function automatic logic [31:0] edge_pattern(input int stages);
    return (32'd1 << stages) - 32'd1;
  endfunction

endpackage

// File: rtl/tx_wkram_dbuf_if.sv
// CPU strobes and consumer read port of tx_wkram_dbuf; i_R1_SEEK exists only
// when TXWKRAM_SEEK_EN is defined.
interface tx_wkram_dbuf_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 6
);
  logic              i_R1_WR;
  logic [DATA_W-1:0] i_R1_WR_DATA;
  logic              i_R1_COPY;
`ifdef TXWKRAM_SEEK_EN
  logic              i_R1_SEEK;
`endif
  logic              i_R2_RD;
  logic [AW-1:0]     i_R2_RD_INDEX;
  logic [DATA_W-1:0] o_R2_OUT_DATA;
  logic [AW-1:0]     o_R2_LEN;
  logic              o_R2_OVF;
  logic [7:0]        o_R2_SEQ;
  logic              o_SWAP_PEND;

  modport master (
`ifdef TXWKRAM_SEEK_EN
    output i_R1_SEEK,
`endif
    output i_R1_WR, i_R1_WR_DATA, i_R1_COPY, i_R2_RD, i_R2_RD_INDEX,
    input  o_R2_OUT_DATA, o_R2_LEN, o_R2_OVF, o_R2_SEQ, o_SWAP_PEND
  );

  modport slave (
`ifdef TXWKRAM_SEEK_EN
    input  i_R1_SEEK,
`endif
    input  i_R1_WR, i_R1_WR_DATA, i_R1_COPY, i_R2_RD, i_R2_RD_INDEX,
    output o_R2_OUT_DATA, o_R2_LEN, o_R2_OVF, o_R2_SEQ, o_SWAP_PEND
  );
endinterface

// File: rtl/tx_wkram_dbuf_strobe_sync.sv
// Synchronises one asynchronous strobe and emits a single-cycle event per pulse;
// the event is valid SYNC_STAGES cycles after the rise, pulses shorter than that are ignored.
module txwk_strobe_sync
  import txwkram_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic evt
);

  localparam logic [31:0] PAT = edge_pattern(SYNC_STAGES);

  logic [SYNC_STAGES:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[SYNC_STAGES-1:0], strobe};
  end

  assign evt = (32'(sr) == PAT);

endmodule

// File: rtl/tx_wkram_dbuf.sv
// Double-buffered status-frame RAM: async CPU strobes fill the write bank, a commit swaps banks
// once the consumer stops reading; 1-cycle reads. Optional TXWKRAM_SEEK_EN adds a write-index seek.
module tx_wkram_dbuf
  import txwkram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 47,
  parameter int SYNC_STAGES = 2
) (
  input logic            i_CLK,
  input logic            i_RST_n,
  tx_wkram_dbuf_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] DEPTH_I = AW'(DEPTH);

  logic wr_evt, copy_evt, seek_evt;

  txwk_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(i_CLK), .rst_n(i_RST_n), .strobe(bus.i_R1_WR), .evt(wr_evt));

  txwk_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_copy_sync (
    .clk(i_CLK), .rst_n(i_RST_n), .strobe(bus.i_R1_COPY), .evt(copy_evt));

`ifdef TXWKRAM_SEEK_EN
  txwk_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_seek_sync (
    .clk(i_CLK), .rst_n(i_RST_n), .strobe(bus.i_R1_SEEK), .evt(seek_evt));
`else
  assign seek_evt = 1'b0;
`endif

  txwk_state_t       state, state_nxt;
  logic              wbank, rbank;
  logic [AW-1:0]     wr_idx, len_pend;
  logic              ovf_acc, ovf_pend;
  logic [AW-1:0]     len_q;
  logic              ovf_q;
  logic [7:0]        seq_q;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] ram [2][1<<AW];

  logic              wr_ok, swap, ovf_wr;
  logic [AW-1:0]     idx_wr, idx_nxt;

  assign rbank = ~wbank;

  // The write always lands at the old index; seek and commit act on the result.
  always_comb begin
    wr_ok   = wr_evt && (wr_idx < DEPTH_I);
    idx_wr  = wr_ok ? wr_idx + AW'(1) : wr_idx;
    ovf_wr  = ovf_acc | (wr_evt & ~wr_ok);
    idx_nxt = idx_wr;
`ifdef TXWKRAM_SEEK_EN
    if (seek_evt)
      idx_nxt = (bus.i_R1_WR_DATA[AW-1:0] > DEPTH_I) ? DEPTH_I : bus.i_R1_WR_DATA[AW-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      ST_IDLE: if (copy_evt) state_nxt = ST_PEND;
      ST_PEND: if (!copy_evt && !bus.i_R2_RD) begin
        state_nxt = ST_IDLE;
        swap      = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wr_idx   <= '0;
      ovf_acc  <= 1'b0;
      len_pend <= '0;
      ovf_pend <= 1'b0;
      wbank    <= 1'b0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      seq_q    <= 8'd0;
      rd_dat   <= '0;
    end else begin
      if (copy_evt) begin
        len_pend <= idx_wr;
        ovf_pend <= ovf_wr;
        wr_idx   <= '0;
        ovf_acc  <= 1'b0;
      end else begin
        wr_idx   <= idx_nxt;
        ovf_acc  <= ovf_wr;
      end
      if (swap) begin
        wbank <= ~wbank;
        len_q <= len_pend;
        ovf_q <= ovf_pend;
        seq_q <= seq_q + 8'd1;
      end
      if (bus.i_R2_RD)
        rd_dat <= (bus.i_R2_RD_INDEX < DEPTH_I) ? ram[rbank][bus.i_R2_RD_INDEX] : '0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (wr_ok) ram[wbank][wr_idx] <= bus.i_R1_WR_DATA;
  end

  assign bus.o_R2_OUT_DATA = rd_dat;
  assign bus.o_R2_LEN      = len_q;
  assign bus.o_R2_OVF      = ovf_q;
  assign bus.o_R2_SEQ      = seq_q;
  assign bus.o_SWAP_PEND   = (state == ST_PEND);

endmodule

// File: tb/tb_tx_wkram_dbuf.sv
// Randomised bench for tx_wkram_dbuf against a frame-level reference model.
module tb_tx_wkram_dbuf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 47;
  localparam int SS     = 2;
  localparam int AW     = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_wkram_dbuf_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  tx_wkram_dbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .i_CLK(clk), .i_RST_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Reference model: frame being written, frame awaiting swap, frame on the read side.
  logic [7:0] m_cur [DEPTH];
  logic [7:0] m_pend[DEPTH];
  logic [7:0] m_rd  [DEPTH];
  int m_widx, m_pend_len, m_rlen, m_seq;
  bit m_wovf, m_pend_ovf, m_rovf;

  function automatic void m_reset();
    m_widx = 0; m_wovf = 0; m_pend_len = 0; m_pend_ovf = 0;
    m_rlen = 0; m_rovf = 0; m_seq = 0;
  endfunction

  function automatic void m_write(input logic [7:0] d);
    if (m_widx < DEPTH) begin
      m_cur[m_widx] = d;
      m_widx++;
    end else m_wovf = 1;
  endfunction

  function automatic void m_commit();
    m_pend = m_cur; m_pend_len = m_widx; m_pend_ovf = m_wovf;
    m_widx = 0; m_wovf = 0;
  endfunction

  function automatic void m_swap();
    m_rd = m_pend; m_rlen = m_pend_len; m_rovf = m_pend_ovf;
    m_seq = (m_seq + 1) % 256;
  endfunction

  task automatic strobe_wr(input logic [7:0] d);
    @(negedge clk);
    bus.i_R1_WR_DATA = d;
    bus.i_R1_WR = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_R1_WR = 1'b0;
    repeat (2) @(negedge clk);
    m_write(d);
  endtask

  // Commit with the read port idle: pending must rise on edge SS+1 and the swap follow on the next.
  task automatic commit(input bit with_wr, input logic [7:0] d, input string tag);
    @(negedge clk);
    if (with_wr) begin
      bus.i_R1_WR_DATA = d;
      bus.i_R1_WR = 1'b1;
    end
    bus.i_R1_COPY = 1'b1;
    repeat (SS) @(negedge clk);
    checks++;
    if (bus.o_SWAP_PEND !== 1'b0) begin
      failures++; $display("FAIL %s pend_early: got %0b want 0", tag, bus.o_SWAP_PEND);
    end
    @(negedge clk);
    checks++;
    if (bus.o_SWAP_PEND !== 1'b1) begin
      failures++; $display("FAIL %s pend_rise: got %0b want 1", tag, bus.o_SWAP_PEND);
    end
    bus.i_R1_WR = 1'b0;
    bus.i_R1_COPY = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_SWAP_PEND !== 1'b0) begin
      failures++; $display("FAIL %s pend_fall: got %0b want 0", tag, bus.o_SWAP_PEND);
    end
    if (with_wr) m_write(d);
    m_commit();
    m_swap();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_R2_LEN !== AW'(m_rlen) || bus.o_R2_OVF !== m_rovf || bus.o_R2_SEQ !== 8'(m_seq)) begin
      failures++;
      $display("FAIL %s frame_info: got len=%0d ovf=%0b seq=%0d want len=%0d ovf=%0b seq=%0d",
               tag, bus.o_R2_LEN, bus.o_R2_OVF, bus.o_R2_SEQ, m_rlen, m_rovf, m_seq);
    end
  endtask

  task automatic read_chk(input int idx, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.i_R2_RD = 1'b1;
    bus.i_R2_RD_INDEX = AW'(idx);
    @(negedge clk);
    bus.i_R2_RD = 1'b0;
    checks++;
    if (bus.o_R2_OUT_DATA !== exp) begin
      failures++; $display("FAIL %s read[%0d]: got %0h want %0h", tag, idx, bus.o_R2_OUT_DATA, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.o_R2_OUT_DATA !== 8'h00 || bus.o_R2_LEN !== '0 || bus.o_R2_OVF !== 1'b0 ||
        bus.o_R2_SEQ !== 8'd0 || bus.o_SWAP_PEND !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%0h len=%0d ovf=%0b seq=%0d pend=%0b want all 0",
               bus.o_R2_OUT_DATA, bus.o_R2_LEN, bus.o_R2_OVF, bus.o_R2_SEQ, bus.o_SWAP_PEND);
    end
  endtask

  task automatic test_basic();
    strobe_wr(8'h11); strobe_wr(8'h22); strobe_wr(8'h33);
    commit(0, 8'h00, "basic");
    read_chk(0, 8'h11, "basic");
    read_chk(1, 8'h22, "basic");
    read_chk(2, 8'h33, "basic");
    checks++;
    if (bus.o_R2_LEN !== AW'(3) || bus.o_R2_SEQ !== 8'd1) begin
      failures++; $display("FAIL basic_len_seq: got len=%0d seq=%0d want 3 1", bus.o_R2_LEN, bus.o_R2_SEQ);
    end
  endtask

  task automatic test_stall();
    logic [7:0] old0;
    old0 = m_rd[0];
    for (int i = 0; i < 4; i++) strobe_wr(8'($urandom));
    @(negedge clk);
    bus.i_R2_RD = 1'b1;
    bus.i_R2_RD_INDEX = '0;
    bus.i_R1_COPY = 1'b1;
    repeat (SS + 1) @(negedge clk);
    bus.i_R1_COPY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_SWAP_PEND !== 1'b1 || bus.o_R2_OUT_DATA !== old0) begin
        failures++;
        $display("FAIL stall_hold: got pend=%0b data=%0h want 1 %0h", bus.o_SWAP_PEND, bus.o_R2_OUT_DATA, old0);
      end
    end
    bus.i_R2_RD = 1'b0;
    @(negedge clk);
    m_commit(); m_swap();
    checks++;
    if (bus.o_SWAP_PEND !== 1'b0 || bus.o_R2_SEQ !== 8'(m_seq) || bus.o_R2_LEN !== AW'(m_rlen)) begin
      failures++;
      $display("FAIL stall_release: got pend=%0b seq=%0d len=%0d want 0 %0d %0d",
               bus.o_SWAP_PEND, bus.o_R2_SEQ, bus.o_R2_LEN, m_seq, m_rlen);
    end
    for (int i = 0; i < 4; i++) read_chk(i, m_rd[i], "stall_new");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) strobe_wr(8'($urandom));
      commit(0, 8'h00, "rand");
      for (int i = 0; i < n; i++) read_chk(i, m_rd[i], "rand");
      read_chk($urandom_range(DEPTH, (1 << AW) - 1), 8'h00, "rand_oob");
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 2; i++) strobe_wr(8'($urandom));
    commit(0, 8'h00, "ovf");
    checks++;
    if (bus.o_R2_LEN !== AW'(DEPTH) || bus.o_R2_OVF !== 1'b1) begin
      failures++; $display("FAIL ovf_flag: got len=%0d ovf=%0b want %0d 1", bus.o_R2_LEN, bus.o_R2_OVF, DEPTH);
    end
    read_chk(DEPTH - 1, m_rd[DEPTH-1], "ovf_last");
    read_chk(0, m_rd[0], "ovf_first");
    strobe_wr(8'h5A); strobe_wr(8'hC3);
    commit(0, 8'h00, "ovf_clear");
    read_chk(1, 8'hC3, "ovf_clear");
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) strobe_wr(8'($urandom));
    d = 8'($urandom);
    commit(1, d, "same");
    checks++;
    if (bus.o_R2_LEN !== AW'(5)) begin
      failures++; $display("FAIL same_len: got %0d want 5", bus.o_R2_LEN);
    end
    read_chk(4, d, "same_last");
    strobe_wr(8'h9E); strobe_wr(8'h4D);
    commit(0, 8'h00, "same_next");
    read_chk(0, 8'h9E, "same_next");
    read_chk(1, 8'h4D, "same_next");
  endtask

  task automatic test_glitch();
    int seq0;
    seq0 = m_seq;
    @(negedge clk); bus.i_R1_WR_DATA = 8'hEE; bus.i_R1_WR = 1'b1;
    @(negedge clk); bus.i_R1_WR = 1'b0;
    @(negedge clk); bus.i_R1_COPY = 1'b1;
    @(negedge clk); bus.i_R1_COPY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_SWAP_PEND !== 1'b0 || bus.o_R2_SEQ !== 8'(seq0)) begin
        failures++; $display("FAIL glitch_copy: got pend=%0b seq=%0d want 0 %0d", bus.o_SWAP_PEND, bus.o_R2_SEQ, seq0);
      end
    end
    commit(0, 8'h00, "glitch_wr");
    checks++;
    if (bus.o_R2_LEN !== '0) begin
      failures++; $display("FAIL glitch_len: got %0d want 0", bus.o_R2_LEN);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) strobe_wr(8'($urandom));
    @(negedge clk);
    bus.i_R2_RD = 1'b1;
    bus.i_R1_COPY = 1'b1;
    repeat (SS + 3) @(negedge clk);
    rst_n = 1'b0;
    bus.i_R1_COPY = 1'b0;
    bus.i_R2_RD = 1'b0;
    @(negedge clk);
    m_reset();
    test_reset();
    rst_n = 1'b1;
    strobe_wr(8'h71); strobe_wr(8'h72);
    commit(0, 8'h00, "post_reset");
    read_chk(0, 8'h71, "post_reset");
    read_chk(1, 8'h72, "post_reset");
  endtask

`ifdef TXWKRAM_SEEK_EN
  task automatic strobe_seek(input logic [7:0] v);
    @(negedge clk);
    bus.i_R1_WR_DATA = v;
    bus.i_R1_SEEK = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_R1_SEEK = 1'b0;
    repeat (2) @(negedge clk);
    m_widx = (int'(v[AW-1:0]) > DEPTH) ? DEPTH : int'(v[AW-1:0]);
  endtask

  task automatic test_seek();
    strobe_seek(8'd10);
    strobe_wr(8'hA5);
    commit(0, 8'h00, "seek");
    checks++;
    if (bus.o_R2_LEN !== AW'(11)) begin
      failures++; $display("FAIL seek_len: got %0d want 11", bus.o_R2_LEN);
    end
    read_chk(10, 8'hA5, "seek");
    strobe_seek(8'd60);
    strobe_wr(8'h3C);
    commit(0, 8'h00, "seek_clamp");
  endtask
`endif

  task automatic test_seq_wrap();
    int guard;
    guard = 0;
    while (m_seq != 0 && guard < 300) begin
      commit(0, 8'h00, "wrap");
      guard++;
    end
    checks++;
    if (bus.o_R2_SEQ !== 8'd0 || guard >= 300) begin
      failures++; $display("FAIL seq_wrap: got %0d want 0 (iterations %0d)", bus.o_R2_SEQ, guard);
    end
  endtask

  initial begin
    bus.i_R1_WR = 1'b0;
    bus.i_R1_WR_DATA = '0;
    bus.i_R1_COPY = 1'b0;
`ifdef TXWKRAM_SEEK_EN
    bus.i_R1_SEEK = 1'b0;
`endif
    bus.i_R2_RD = 1'b0;
    bus.i_R2_RD_INDEX = '0;
    m_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_random_frames();
    test_overflow();
    test_same_cycle();
    test_glitch();
    test_reset_mid();
`ifdef TXWKRAM_SEEK_EN
    test_seek();
`endif
    test_seq_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_wkram_dbuf.md
# tx_wkram_dbuf

Parametrised double-buffered work RAM that carries a status frame from the CPU-side writer to a consumer running on i_CLK. Byte strobes from the CPU arrive asynchronously and fill the write bank sequentially. A commit strobe seals the frame, and the banks are swapped once the consumer is not reading. Compared with the fixed 47-byte predecessor, it adds configurable width, depth and synchroniser depth, plus frame length capture, overflow flagging, a frame sequence counter and a swap-pending indication.

## Interface
- DATA_W, 8, data width of each RAM word
- DEPTH, 47, words per bank (2..127)
- SYNC_STAGES, 2, synchroniser flops on each async strobe (>=2)
- AW (localparam), $clog2(DEPTH+1), index width

Ports:
- i_CLK  in  1  single clock for the whole block
- i_RST_n  in  1  reset, asynchronous, active-low
- i_R1_WR  in  1  CPU-domain write strobe, asynchronous
- i_R1_WR_DATA  in  DATA_W  write data; held stable while i_R1_WR is high
- i_R1_COPY  in  1  CPU-domain commit strobe, asynchronous
- i_R2_RD  in  1  read enable, i_CLK domain
- i_R2_RD_INDEX  in  AW  read index
- o_R2_OUT_DATA  out  DATA_W  registered read data
- o_R2_LEN  out  AW  word count of the frame in the read bank
- o_R2_OVF  out  1  the frame in the read bank overflowed
- o_R2_SEQ  out  8  count of completed swaps
- o_SWAP_PEND  out  1  a commit is waiting for its swap

## Operation
- Strobe events:
  - Each strobe is shifted into a register SYNC_STAGES+1 bits wide.
  - An event fires when that register equals {1'b0, SYNC_STAGES ones}. This is 3'b011 at the default setting.
  - Each strobe pulse produces exactly one event. Glitches narrower than SYNC_STAGES cycles produce none.
- Write event:
  - While wr_idx < DEPTH: store the data at ram[wbank][wr_idx] and increment wr_idx.
  - While wr_idx == DEPTH: drop the data, hold wr_idx, and set ovf_acc.
- Commit event:
  - Latch len_pend = wr_idx and ovf_pend = ovf_acc.
  - Clear wr_idx and ovf_acc.
  - Move FSM IDLE→PEND.
- A write event and a commit event in the same cycle: the write is performed first at the old index and is counted into len_pend (len_pend = wr_idx+1, saturating at DEPTH).
- Commit while in PEND: len_pend and ovf_pend are overwritten. Writes since the first commit went into the same write bank, so the frames merge. The swap is still single.
- FSM transition PEND→IDLE happens on the first cycle with i_R2_RD low, never in the same cycle as the commit event. On that transition:
  - wbank and rbank toggle.
  - o_R2_LEN ← len_pend, o_R2_OVF ← ovf_pend.
  - o_R2_SEQ increments, wrapping 255→0.
- Reads: when i_R2_RD is high, o_R2_OUT_DATA ← ram[rbank][index]. An index >= DEPTH returns 0. When i_R2_RD is low, the output holds.
- o_SWAP_PEND = (state == PEND).

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - wbank=0, rbank=1.
  - wr_idx=0, ovf_acc=0.
  - Synchroniser registers 0.
  - RAM contents are not reset.
- Write latency: the RAM is written on the (SYNC_STAGES+1)th i_CLK edge after i_R1_WR rises. The data must stay stable until then.
- Commit latency: o_SWAP_PEND rises SYNC_STAGES+1 edges after i_R1_COPY rises. The swap follows one cycle later at the earliest, and is stalled for as long as i_R2_RD is high.
- Read latency: 1 cycle.
- Reset asserted mid-frame or mid-PEND discards the partial frame and the pending swap.

## Configuration
- TXWKRAM_SEEK_EN defined:
  - Adds input i_R1_SEEK (async, synchronised identically to the other strobes).
  - A seek event loads wr_idx ← i_R1_WR_DATA[AW-1:0], clamped to DEPTH, and leaves ovf_acc unchanged.
  - A seek and a write in the same cycle: the write uses the old index, then the seek value is loaded.
- Without the macro: the port is absent and writes are purely sequential.

## Structure
- Package txwkram_pkg holds:
  - typedef enum logic {ST_IDLE, ST_PEND} txwk_state_t
  - function edge_pattern(stages)
- Sub-module txwk_strobe_sync contains the synchroniser and event detector, parameter SYNC_STAGES. It is instantiated 2× (3× with TXWKRAM_SEEK_EN).

## Test plan
- Reset, 3 writes 0x11/0x22/0x33, commit, reads of index 0..2 → 0x11/0x22/0x33; o_R2_LEN=3, o_R2_SEQ=1, o_R2_OVF=0.
- Hold i_R2_RD high through a commit → o_SWAP_PEND stays 1 and the old data is still read. Drop i_R2_RD → the swap occurs the next cycle and o_SWAP_PEND falls.
- DEPTH+2 writes, then commit → o_R2_LEN=DEPTH, o_R2_OVF=1, and the last in-range word is intact.
- Write event and commit event in the same cycle after 4 writes → o_R2_LEN=5; the next frame starts at index 0.
- 256 commit/swap cycles → o_R2_SEQ wraps to 0. A strobe pulse 1 cycle wide → no write.
- With TXWKRAM_SEEK_EN: seek 10, write 0xA5, commit → ram index 10 = 0xA5, o_R2_LEN=11.
